// File: rtl/icache_refill_unit.sv
// icache_refill_unit
// Memory-side responder for ICache misses: takes one miss at a time, reads the
// line as BEATS sequential bus beats (one outstanding request), assembles them
// LSB-first and hands the line back together with its aligned address and way.

module icache_refill_unit #(
   parameter int PLEN        = 32,
   parameter int LINE_WIDTH  = 256,
   parameter int BUS_WIDTH   = 32,
   parameter int WAY_WIDTH   = 2,
   parameter int INDEX_WIDTH = 6
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   // miss request from the frontend
   input  logic                   miss_req_valid_i,
   output logic                   miss_req_ready_o,
   input  logic [PLEN-1:0]        miss_req_paddr_i,
   input  logic [WAY_WIDTH-1:0]   miss_req_victim_way_i,
   input  logic [INDEX_WIDTH-1:0] miss_req_index_i,
   // refill back to the ICache
   output logic                   refill_valid_o,
   input  logic                   refill_ready_i,
   output logic [PLEN-1:0]        refill_paddr_o,
   output logic [WAY_WIDTH-1:0]   refill_way_o,
   output logic [LINE_WIDTH-1:0]  refill_data_o,
   // memory bus
   output logic                   mem_req_valid_o,
   input  logic                   mem_req_ready_i,
   output logic [PLEN-1:0]        mem_req_addr_o,
   input  logic                   mem_rsp_valid_i,
   output logic                   mem_rsp_ready_o,
   input  logic [BUS_WIDTH-1:0]   mem_rsp_data_i,
   // status
   output logic                   busy_o
);

   localparam int LINE_BYTES = LINE_WIDTH / 8;
   localparam int OFF        = $clog2(LINE_BYTES);
   localparam int BEATS      = LINE_WIDTH / BUS_WIDTH;
   localparam int BEAT_BYTES = BUS_WIDTH / 8;
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
   localparam logic [PLEN-1:0]  OFF_MASK  = PLEN'(LINE_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MEM_REQ,
      S_MEM_WAIT,
      S_REFILL
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [PLEN-1:0]       r_base;
   logic [WAY_WIDTH-1:0]  r_way;
   logic [CNT_W-1:0]      r_cnt;
   logic [LINE_WIDTH-1:0] r_line;

   logic                  w_miss_fire;
   logic                  w_req_fire;
   logic                  w_beat_fire;
   logic                  w_refill_fire;
   logic                  w_last_beat;
   logic [PLEN-1:0]       w_beat_offset;

   assign w_miss_fire   = miss_req_valid_i && miss_req_ready_o;
   assign w_req_fire    = mem_req_valid_o && mem_req_ready_i;
   // A response only counts while waiting for one; anything else on the bus is dropped.
   assign w_beat_fire   = mem_rsp_valid_i && mem_rsp_ready_o;
   assign w_refill_fire = refill_valid_o && refill_ready_i;
   assign w_last_beat   = (r_cnt == LAST_BEAT);
   assign w_beat_offset = PLEN'(r_cnt) * PLEN'(BEAT_BYTES);

   // State register; reset abandons any in-flight beat.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:     if (w_miss_fire)   w_next_state = S_MEM_REQ;
         S_MEM_REQ:  if (w_req_fire)    w_next_state = S_MEM_WAIT;
         S_MEM_WAIT: if (w_beat_fire)   w_next_state = w_last_beat ? S_REFILL : S_MEM_REQ;
         S_REFILL:   if (w_refill_fire) w_next_state = S_IDLE;
         default:                       w_next_state = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register.
   always_comb begin
      miss_req_ready_o = 1'b0;
      mem_req_valid_o  = 1'b0;
      mem_rsp_ready_o  = 1'b0;
      refill_valid_o   = 1'b0;
      case (r_state)
         S_IDLE:     miss_req_ready_o = 1'b1;
         S_MEM_REQ:  mem_req_valid_o  = 1'b1;
         S_MEM_WAIT: mem_rsp_ready_o  = 1'b1;
         S_REFILL:   refill_valid_o   = 1'b1;
         default:    ;
      endcase
   end

   // Miss capture, beat counter and line assembly (beat 0 lands in the LSBs).
   // NOTE: the line buffer is cleared on reset and on each accept so no stale beats leak.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_base <= '0;
         r_way  <= '0;
         r_cnt  <= '0;
         r_line <= '0;
      end else if (w_miss_fire) begin
         r_base <= miss_req_paddr_i & ~OFF_MASK;
         r_way  <= miss_req_victim_way_i;
         r_cnt  <= '0;
         r_line <= '0;
      end else if (w_beat_fire) begin
         for (int b = 0; b < BEATS; b++) begin
            if (r_cnt == CNT_W'(b)) r_line[b*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data_i;
         end
         // The counter stops on the last beat; the next accept restarts it.
         if (!w_last_beat) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Base is line-aligned, so the beat address never carries past the top of memory.
   assign mem_req_addr_o = r_base + w_beat_offset;
   assign refill_paddr_o = r_base;
   assign refill_way_o   = r_way;
   assign refill_data_o  = r_line;
   assign busy_o         = (r_state != S_IDLE);

   // The separately supplied index must agree with the address it came from.
   a_index_consistent : assert property (@(posedge clk_i) disable iff (rst_i)
      w_miss_fire |-> (miss_req_index_i == miss_req_paddr_i[OFF +: INDEX_WIDTH]));

   // Valid/ready outputs are always known once out of reset.
   a_valids_known : assert property (@(posedge clk_i) disable iff (rst_i)
      !$isunknown({miss_req_ready_o, refill_valid_o, mem_req_valid_o, mem_rsp_ready_o}));

endmodule

// File: tb/tb_icache_refill_unit.sv
// Testbench for icache_refill_unit: directed miss scenarios drive the ports,
// expected beat addresses and refill lines go into queues, and a negedge
// monitor pops and compares them at every handshake.

module tb_icache_refill_unit;

   localparam int PLEN        = 32;
   localparam int LINE_WIDTH  = 256;
   localparam int BUS_WIDTH   = 32;
   localparam int WAY_WIDTH   = 2;
   localparam int INDEX_WIDTH = 6;
   localparam int OFF         = 5;
   localparam int BEATS       = 8;
   localparam int WAIT_LIMIT  = 200;

   typedef struct packed {
      logic [PLEN-1:0]       paddr;
      logic [WAY_WIDTH-1:0]  way;
      logic [LINE_WIDTH-1:0] data;
   } refill_t;

   logic                   clk_i;
   logic                   rst_i;
   logic                   miss_req_valid_i;
   logic                   miss_req_ready_o;
   logic [PLEN-1:0]        miss_req_paddr_i;
   logic [WAY_WIDTH-1:0]   miss_req_victim_way_i;
   logic [INDEX_WIDTH-1:0] miss_req_index_i;
   logic                   refill_valid_o;
   logic                   refill_ready_i;
   logic [PLEN-1:0]        refill_paddr_o;
   logic [WAY_WIDTH-1:0]   refill_way_o;
   logic [LINE_WIDTH-1:0]  refill_data_o;
   logic                   mem_req_valid_o;
   logic                   mem_req_ready_i;
   logic [PLEN-1:0]        mem_req_addr_o;
   logic                   mem_rsp_valid_i;
   logic                   mem_rsp_ready_o;
   logic [BUS_WIDTH-1:0]   mem_rsp_data_i;
   logic                   busy_o;

   icache_refill_unit #(
      .PLEN(PLEN), .LINE_WIDTH(LINE_WIDTH), .BUS_WIDTH(BUS_WIDTH),
      .WAY_WIDTH(WAY_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)
   ) dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .miss_req_valid_i      (miss_req_valid_i),
      .miss_req_ready_o      (miss_req_ready_o),
      .miss_req_paddr_i      (miss_req_paddr_i),
      .miss_req_victim_way_i (miss_req_victim_way_i),
      .miss_req_index_i      (miss_req_index_i),
      .refill_valid_o        (refill_valid_o),
      .refill_ready_i        (refill_ready_i),
      .refill_paddr_o        (refill_paddr_o),
      .refill_way_o          (refill_way_o),
      .refill_data_o         (refill_data_o),
      .mem_req_valid_o       (mem_req_valid_o),
      .mem_req_ready_i       (mem_req_ready_i),
      .mem_req_addr_o        (mem_req_addr_o),
      .mem_rsp_valid_i       (mem_rsp_valid_i),
      .mem_rsp_ready_o       (mem_rsp_ready_o),
      .mem_rsp_data_i        (mem_rsp_data_i),
      .busy_o                (busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Scoreboard state
   int               vectors     = 0;
   int               miscompares = 0;
   logic [PLEN-1:0]  exp_addr_q[$];
   refill_t          exp_ref_q[$];
   int               mem_hs_cnt    = 0;
   int               refill_hs_cnt = 0;
   int               accept_edge   = 0;
   int               refill_edge   = 0;
   int               beat_idx      = 0;
   bit               lat_en        = 1'b0;
   logic             prev_refill_valid = 1'b0;

   task automatic check(input string name, input logic [LINE_WIDTH-1:0] act,
                        input logic [LINE_WIDTH-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [LINE_WIDTH-1:0] make_line(input logic [PLEN-1:0] base);
      logic [LINE_WIDTH-1:0] l;
      l = '0;
      for (int k = 0; k < BEATS; k++) l[k*BUS_WIDTH +: BUS_WIDTH] = base + PLEN'(4*k);
      return l;
   endfunction

   // Monitor: sees the value each signal will have at the next rising edge.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (miss_req_valid_i && miss_req_ready_o) begin
            accept_edge = cyc + 1;
            beat_idx    = 0;
         end
         if (mem_req_valid_o && mem_req_ready_i) begin
            mem_hs_cnt++;
            check("mem_expect_avail", exp_addr_q.size() > 0, 1'b1);
            if (exp_addr_q.size() > 0) check("mem_addr", mem_req_addr_o, exp_addr_q.pop_front());
            if (lat_en) check("beat_req_edge", cyc + 1 - accept_edge, 1 + 2*beat_idx);
            beat_idx++;
         end
         if (refill_valid_o && !prev_refill_valid && lat_en)
            check("refill_latency", cyc + 1 - accept_edge, 17);
         if (refill_valid_o && refill_ready_i) begin
            refill_t e;
            refill_hs_cnt++;
            refill_edge = cyc + 1;
            check("refill_expect_avail", exp_ref_q.size() > 0, 1'b1);
            if (exp_ref_q.size() > 0) begin
               e = exp_ref_q.pop_front();
               check("refill_paddr", refill_paddr_o, e.paddr);
               check("refill_way", refill_way_o, e.way);
               check("refill_data", refill_data_o, e.data);
            end
         end
         prev_refill_valid = refill_valid_o;
      end else begin
         prev_refill_valid = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return mem_req_valid_o;
         1:       return refill_valid_o;
         default: return miss_req_ready_o;
      endcase
   endfunction

   task automatic wait_sig(input int which, input string name);
      for (int i = 0; i < WAIT_LIMIT && !sig(which); i++) step();
      check({name, "_wait"}, sig(which), 1'b1);
   endtask

   // Drive a miss and queue everything it should produce.
   task automatic set_miss(input logic [PLEN-1:0] paddr, input logic [WAY_WIDTH-1:0] way);
      logic [PLEN-1:0] base;
      refill_t r;
      base = paddr & ~32'h1F;
      for (int k = 0; k < BEATS; k++) exp_addr_q.push_back(base + PLEN'(4*k));
      r.paddr = base;
      r.way   = way;
      r.data  = make_line(base);
      exp_ref_q.push_back(r);
      miss_req_paddr_i      = paddr;
      miss_req_victim_way_i = way;
      miss_req_index_i      = paddr[OFF +: INDEX_WIDTH];
      miss_req_valid_i      = 1'b1;
   endtask

   task automatic finish_accept();
      wait_sig(2, "miss_ready");
      step();
      miss_req_valid_i = 1'b0;
   endtask

   // One beat: optional request stall (with optional spurious response), optional response delay.
   task automatic serve_beat(input logic [PLEN-1:0] addr, input int req_stall,
                             input int rsp_delay, input bit spurious);
      wait_sig(0, "mem_req_valid");
      for (int i = 0; i < req_stall; i++) begin
         check("mem_addr_hold", mem_req_addr_o, addr);
         if (spurious) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = 32'hDEAD_BEEF;
            check("rsp_ready_in_req", mem_rsp_ready_o, 1'b0);
         end
         step();
      end
      mem_rsp_valid_i = 1'b0;
      mem_req_ready_i = 1'b1;
      step();
      mem_req_ready_i = 1'b0;
      for (int i = 0; i < rsp_delay; i++) step();
      check("rsp_ready_in_wait", mem_rsp_ready_o, 1'b1);
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = addr;
      step();
      mem_rsp_valid_i = 1'b0;
   endtask

   task automatic serve_line(input logic [PLEN-1:0] base, input int stall_beat, input int stall_n,
                             input int delay_beat, input int delay_n, input int spur_beat);
      for (int k = 0; k < BEATS; k++)
         serve_beat(base + PLEN'(4*k), (k == stall_beat) ? stall_n : 0,
                    (k == delay_beat) ? delay_n : 0, k == spur_beat);
   endtask

   task automatic accept_refill(input logic [PLEN-1:0] paddr, input logic [WAY_WIDTH-1:0] way,
                                input int stall, input bit miss_blocked);
      logic [LINE_WIDTH-1:0] line;
      line = make_line(paddr);
      wait_sig(1, "refill_valid");
      for (int i = 0; i < stall; i++) begin
         check("refill_paddr_hold", refill_paddr_o, paddr);
         check("refill_way_hold", refill_way_o, way);
         check("refill_data_hold", refill_data_o, line);
         if (miss_blocked) check("miss_blocked_in_refill", miss_req_ready_o, 1'b0);
         step();
      end
      refill_ready_i = 1'b1;
      if (miss_blocked) check("miss_blocked_at_hs", miss_req_ready_o, 1'b0);
      step();
      refill_ready_i = 1'b0;
   endtask

   initial begin
      int h_mem;
      int h_ref;
      rst_i                 = 1'b1;
      miss_req_valid_i      = 1'b0;
      miss_req_paddr_i      = '0;
      miss_req_victim_way_i = '0;
      miss_req_index_i      = '0;
      refill_ready_i        = 1'b0;
      mem_req_ready_i       = 1'b0;
      mem_rsp_valid_i       = 1'b0;
      mem_rsp_data_i        = '0;

      // Reset state
      repeat (2) step();
      check("rst_miss_ready", miss_req_ready_o, 1'b1);
      check("rst_refill_valid", refill_valid_o, 1'b0);
      check("rst_mem_req_valid", mem_req_valid_o, 1'b0);
      check("rst_mem_rsp_ready", mem_rsp_ready_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_refill_paddr", refill_paddr_o, 32'h0);
      check("rst_refill_way", refill_way_o, 2'd0);
      check("rst_refill_data", refill_data_o, '0);
      rst_i = 1'b0;
      step();

      // Basic miss with exact latency
      lat_en = 1'b1;
      set_miss(32'h8000_0014, 2'd2);
      finish_accept();
      serve_line(32'h8000_0000, -1, 0, -1, 0, -1);
      accept_refill(32'h8000_0000, 2'd2, 0, 1'b0);
      lat_en = 1'b0;
      step();

      // Back-pressure on request, response and refill
      h_mem = mem_hs_cnt;
      h_ref = refill_hs_cnt;
      set_miss(32'h2000_0ABC, 2'd0);
      finish_accept();
      serve_line(32'h2000_0AA0, 0, 3, 7, 5, -1);
      accept_refill(32'h2000_0AA0, 2'd0, 4, 1'b0);
      step();
      check("bp_mem_handshakes", mem_hs_cnt - h_mem, 8);
      check("bp_refill_handshakes", refill_hs_cnt - h_ref, 1);

      // Back-to-back: second miss waits through REFILL
      set_miss(32'h4000_0100, 2'd3);
      finish_accept();
      serve_line(32'h4000_0100, -1, 0, -1, 0, -1);
      set_miss(32'h4000_2264, 2'd1);
      accept_refill(32'h4000_0100, 2'd3, 2, 1'b1);
      check("b2b_ready_after_refill", miss_req_ready_o, 1'b1);
      finish_accept();
      check("b2b_accept_edge", accept_edge - refill_edge, 1);
      serve_line(32'h4000_2260, -1, 0, -1, 0, -1);
      accept_refill(32'h4000_2260, 2'd1, 0, 1'b0);
      step();

      // Spurious response while a request is pending
      set_miss(32'h0000_0004, 2'd1);
      finish_accept();
      serve_line(32'h0000_0000, 3, 2, -1, 0, 3);
      accept_refill(32'h0000_0000, 2'd1, 1, 1'b0);
      step();

      // Top line of the address space
      set_miss(32'hFFFF_FFE4, 2'd3);
      finish_accept();
      serve_line(32'hFFFF_FFE0, -1, 0, -1, 0, -1);
      accept_refill(32'hFFFF_FFE0, 2'd3, 0, 1'b0);
      step();

      // Reset in the middle of MEM_WAIT
      set_miss(32'h1234_5678, 2'd1);
      finish_accept();
      serve_beat(32'h1234_5660, 0, 0, 1'b0);
      serve_beat(32'h1234_5664, 0, 0, 1'b0);
      wait_sig(0, "mem_req_valid");
      mem_req_ready_i = 1'b1;
      step();
      mem_req_ready_i = 1'b0;
      check("pre_rst_in_wait", mem_rsp_ready_o, 1'b1);
      rst_i = 1'b1;
      #1;
      check("midrst_refill_valid", refill_valid_o, 1'b0);
      check("midrst_mem_req_valid", mem_req_valid_o, 1'b0);
      check("midrst_mem_rsp_ready", mem_rsp_ready_o, 1'b0);
      check("midrst_miss_ready", miss_req_ready_o, 1'b1);
      check("midrst_busy", busy_o, 1'b0);
      exp_addr_q.delete();
      exp_ref_q.delete();
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'hBAD0_BAD0;
      step();
      rst_i = 1'b0;
      step();
      check("late_rsp_not_taken", mem_rsp_ready_o, 1'b0);
      check("late_rsp_idle", busy_o, 1'b0);
      mem_rsp_valid_i = 1'b0;
      set_miss(32'h0000_1040, 2'd1);
      finish_accept();
      serve_line(32'h0000_1040, -1, 0, -1, 0, -1);
      accept_refill(32'h0000_1040, 2'd1, 0, 1'b0);

      repeat (3) step();
      check("mem_queue_drained", exp_addr_q.size(), 0);
      check("refill_queue_drained", exp_ref_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1);
   end

endmodule
